sc_stream_sequencer: RTL and testbench
======================================

// Module: sc_stream_sequencer
// PURPOSE
//  Sequences one stochastic-computing evaluation of an LFSR/comparator SNG circuit.
//  Loads the SNG seed and clears the circuit's feedback register. Runs the stream for LEN cycles.
//  Counts the ones on the circuit's output bit to give a binary result, with a start/done handshake.
//  Sits between the host/register interface and the SC datapath; it is the only driver of the datapath's load/run controls.
// PARAMETERS
//  WIDTH   8    LFSR / comparator width (seed and operand width)
//  LEN     256  counted stream length in cycles, legal range 1..65535
//  WARMUP  4    cycles run but not counted, to let the feedback register settle; only used when SC_WARMUP_EN is defined
//  CNT_W   $clog2(LEN+1)  result width (localparam, derived; 9 for LEN=256)
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      asynchronous reset, active low
//  start     in   1      request an evaluation; sampled only in IDLE
//  abort     in   1      cancel a running evaluation
//  seed      in   WIDTH  SNG seed for this evaluation, captured on accepted start
//  sc_bit    in   1      stochastic output bit from the datapath (output_circuit)
//  sc_load   out  1      datapath: load sc_seed into the LFSR this cycle
//  sc_seed   out  WIDTH  seed value presented with sc_load
//  sc_clr    out  1      datapath: clear the feedback register (out_x_1) this cycle
//  sc_run    out  1      datapath: advance the LFSR / feedback register this cycle
//  busy      out  1      high from the cycle after an accepted start until DONE is left
//  done      out  1      one-cycle pulse when result becomes valid
//  result    out  CNT_W  count of ones over the LEN counted cycles; held until the next done
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; every output is 0, including result and sc_seed.
//  - FSM states: IDLE, LOAD, WARM, RUN, DONE.
//  - IDLE: start=1 -> LOAD; seed is captured that cycle. start=0 -> stay in IDLE.
//  - LOAD (1 cycle): sc_load=1, sc_clr=1, sc_run=0.
//      sc_seed = captured seed, except seed==0 is replaced by 1 (all-zero LFSR lock-up guard).
//      Counter cleared. Next state is WARM, or RUN when the warm-up feature is compiled out.
//  - WARM (WARMUP cycles): sc_run=1; sc_bit is ignored. Goes to RUN after the last warm-up cycle.
//  - RUN (LEN cycles): sc_run=1; counter += sc_bit each cycle. Goes to DONE after the LEN-th cycle.
//      sc_bit is sampled in the same cycle that sc_run is high.
//  - DONE (1 cycle): done=1; result <= final count, visible in the same cycle as done; busy=1. Then -> IDLE.
//  - Latency from accepted start to done: 1 + WARMUP + LEN + 1 cycles with warm-up compiled in, 2 + LEN without.
//  - Count never wraps: CNT_W holds LEN exactly (all ones -> result=LEN).
//  - start while busy: ignored, not queued. start in the same cycle DONE returns to IDLE: ignored; a new start is needed from IDLE.
//  - abort in LOAD/WARM/RUN -> IDLE next cycle. No done pulse; result keeps its previous value; sc_run drops immediately.
//      abort in IDLE or DONE: no effect.
//  - abort and DONE in the same cycle: done is still issued.
//  - rst_n low mid-evaluation: all outputs go to 0 asynchronously; the evaluation is lost.
// CONFIGURATION
//  SC_WARMUP_EN defined: the WARM state exists and runs WARMUP uncounted cycles.
//  SC_WARMUP_EN undefined: the WARM state and its counter are removed; LOAD goes straight to RUN; WARMUP is ignored.
// STRUCTURE
//  - Package sc_seq_pkg holds:
//      state enum sc_seq_state_t {IDLE, LOAD, WARM, RUN, DONE}
//      SEED_ZERO_SUB = 'd1
//  - One sub-module, sc_ones_counter (clear, enable, bit in, CNT_W count out, parameter CNT_W).
//  - The cycle down-counter for WARM/RUN and the FSM stay in the top level.
// TESTING
//  1. sc_bit=1 constant, seed=8'hA5, WARMUP=4, LEN=256 -> result=9'h100; done exactly 262 cycles after start; sc_run high for 260 cycles.
//  2. sc_bit=0 constant -> result=0 and done pulses once; then sc_bit toggling 1,0 -> result=128.
//  3. seed=8'h00 -> sc_seed=8'h01 with sc_load=1, sc_clr=1 for exactly one cycle.
//  4. start pulsed every cycle while busy -> exactly one done per evaluation.
//     abort in RUN cycle 100 -> IDLE next cycle, no done, result keeps the previous value (128).
//  5. rst_n low in RUN -> busy, sc_run, result all 0 before the next clk edge; start after release runs normally.
//  6. Compiled without SC_WARMUP_EN, LEN=256 -> done 258 cycles after start; sc_bit forced to 1 during the would-be warm-up window is still counted.

Source files
------------

// File: rtl/sc_seq_pkg.sv
// Shared types and constants for the stochastic-computing stream sequencer.
package sc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } sc_seq_state_t;

  // An all-zero seed would lock the LFSR up, so it is replaced by this value.
  localparam int SEED_ZERO_SUB = 'd1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sc_stream_sequencer_if.sv
// Host-side start/done handshake of the stream sequencer.
// master = host/register side, slave = sequencer.
interface sc_stream_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 9
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;

  modport master (
    output start, abort, seed,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, seed,
    output busy, done, result
  );
endinterface

// File: rtl/sc_ones_counter.sv
// Counts ones on the stochastic output bit. CNT_W must be wide enough to hold
// the full stream length so the count never wraps.
module sc_ones_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Accumulate sc_bit while enabled; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + CNT_W'(bit_in);
  end

  assign count = count_q;

endmodule

// File: rtl/sc_stream_sequencer.sv
// Sequences one stochastic-computing evaluation: load seed / clear feedback,
// optional uncounted warm-up, LEN counted cycles, then a one-cycle done.
// Optional feature macro: SC_WARMUP_EN (adds the WARM state and WARMUP cycles).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; seed captured on accepted start
//   LOAD  | sc_load + sc_clr for one cycle, ones counter cleared
//   WARM  | sc_run, bit ignored for WARMUP cycles (SC_WARMUP_EN only)
//   RUN   | sc_run, ones counted for LEN cycles
//   DONE  | done pulse, result valid, then back to IDLE
module sc_stream_sequencer
  import sc_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LEN    = 256,
  parameter int WARMUP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sc_stream_sequencer_if.slave  host,
  input  logic                  sc_bit,
  output logic                  sc_load,
  output logic [WIDTH-1:0]      sc_seed,
  output logic                  sc_clr,
  output logic                  sc_run
);

  localparam int CNT_W = $clog2(LEN + 1);
  // Shared down-counter for WARM and RUN, sized for the longer of the two.
  localparam int TMR_W = max_int($clog2(LEN + 1), $clog2(WARMUP + 1));
  localparam logic [TMR_W-1:0] TMR_RUN  = TMR_W'(LEN - 1);
  localparam logic [TMR_W-1:0] TMR_WARM = TMR_W'(WARMUP - 1);

  sc_seq_state_t    state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_tc;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] result_q;
  logic [CNT_W-1:0] cnt;

  assign tmr_tc = (tmr_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort only matters while an evaluation is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (host.start) state_d = LOAD;
      LOAD: begin
        if (host.abort) state_d = IDLE;
        else begin
`ifdef SC_WARMUP_EN
          state_d = WARM;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef SC_WARMUP_EN
      WARM: begin
        if (host.abort)  state_d = IDLE;
        else if (tmr_tc) state_d = RUN;
      end
`endif
      RUN: begin
        if (host.abort)  state_d = IDLE;
        else if (tmr_tc) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cycle down-counter: loaded on entry to each timed phase, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else begin
      case (state_q)
`ifdef SC_WARMUP_EN
        LOAD: tmr_q <= TMR_WARM;
        WARM: tmr_q <= tmr_tc ? TMR_RUN : tmr_q - TMR_W'(1);
`else
        LOAD: tmr_q <= TMR_RUN;
`endif
        RUN:     if (!tmr_tc) tmr_q <= tmr_q - TMR_W'(1);
        default: tmr_q <= tmr_q;
      endcase
    end
  end

  // Seed capture on accepted start, with the zero-seed substitution applied here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seed_q <= '0;
    else if (state_q == IDLE && host.start)
      seed_q <= (host.seed == '0) ? WIDTH'(SEED_ZERO_SUB) : host.seed;
  end

  // Result hold register; updated only by a completed evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                result_q <= '0;
    else if (state_q == DONE)  result_q <= cnt;
  end

  sc_ones_counter #(.CNT_W(CNT_W)) u_ones (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == LOAD),
    .enable (state_q == RUN && sc_run),
    .bit_in (sc_bit),
    .count  (cnt)
  );

  // Outputs; sc_run is gated by abort so the datapath stops in the abort cycle,
  // and result shows the live count during DONE so it is valid with done.
  always_comb begin
    sc_load     = 1'b0;
    sc_clr      = 1'b0;
    sc_run      = 1'b0;
    sc_seed     = '0;
    host.done   = 1'b0;
    host.busy   = (state_q != IDLE);
    host.result = result_q;
    case (state_q)
      LOAD: begin
        sc_load = 1'b1;
        sc_clr  = 1'b1;
        sc_seed = seed_q;
      end
      WARM: sc_run = !host.abort;
      RUN:  sc_run = !host.abort;
      DONE: begin
        host.done   = 1'b1;
        host.result = cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Directed bench for sc_stream_sequencer with a result scoreboard.
module tb_sc_stream_sequencer;

  localparam int WIDTH  = 8;
  localparam int LEN    = 256;
  localparam int WARMUP = 4;
  localparam int CNT_W  = 9;
`ifdef SC_WARMUP_EN
  localparam int WARM_C = WARMUP;
`else
  localparam int WARM_C = 0;
`endif
  localparam int RUN_FIRST = 2 + WARM_C;     // cycle index of first counted cycle
  localparam int LAT       = 2 + WARM_C + LEN;

  logic             clk;
  logic             rst_n;
  logic             sc_bit;
  logic             sc_load;
  logic [WIDTH-1:0] sc_seed;
  logic             sc_clr;
  logic             sc_run;

  int vectors;
  int miscompares;
  int exp_q[$];
  int last_exp;

  sc_stream_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) host_if ();

  sc_stream_sequencer #(.WIDTH(WIDTH), .LEN(LEN), .WARMUP(WARMUP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host_if),
    .sc_bit  (sc_bit),
    .sc_load (sc_load),
    .sc_seed (sc_seed),
    .sc_clr  (sc_clr),
    .sc_run  (sc_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Bit pattern driven during cycle c (c=0 is the start cycle).
  function automatic logic pat_bit(input int pat, input int c);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return c[0];
      default: return (c >= 2 && c <= 5);
    endcase
  endfunction

  function automatic int model_count(input int pat);
    int n = 0;
    for (int c = RUN_FIRST; c < RUN_FIRST + LEN; c++) n += int'(pat_bit(pat, c));
    return n;
  endfunction

  // One evaluation; abort_c >= 0 asserts abort during that cycle index.
  task automatic run_eval(input string tag, input logic [7:0] s, input int pat,
                          input bit hold_start, input int abort_c);
    int dones = 0, runs = 0, loads = 0, clrs = 0, done_c = -1;
    int exp_seed;
    exp_seed = (s == 8'h00) ? 1 : int'(s);
    @(posedge clk); #1;
    host_if.start = 1'b1;
    host_if.seed  = s;
    sc_bit        = pat_bit(pat, 0);
    if (abort_c < 0) exp_q.push_back(model_count(pat));
    for (int c = 1; c <= LAT + 4; c++) begin
      @(posedge clk); #1;
      host_if.start = hold_start && (dones == 0);
      host_if.abort = (c == abort_c);
      sc_bit        = pat_bit(pat, c);
      #3;
      if (host_if.done) begin
        dones++;
        done_c = c;
        if (exp_q.size() == 0) chk({tag, " unexpected done"}, 1, 0);
        else begin
          last_exp = exp_q.pop_front();
          chk({tag, " result"}, 32'(host_if.result), last_exp);
        end
      end
      if (sc_run)  runs++;
      if (sc_load) loads++;
      if (sc_clr)  clrs++;
      if (c == 1) begin
        chk({tag, " load"}, 32'(sc_load), 1);
        chk({tag, " clr"},  32'(sc_clr), 1);
        chk({tag, " seed"}, 32'(sc_seed), exp_seed);
        chk({tag, " busy"}, 32'(host_if.busy), 1);
      end
      if (c == abort_c) chk({tag, " run drops on abort"}, 32'(sc_run), 0);
      if (abort_c >= 0 && c == abort_c + 1) chk({tag, " idle after abort"}, 32'(host_if.busy), 0);
    end
    host_if.abort = 1'b0;
    host_if.start = 1'b0;
    chk({tag, " idle at end"}, 32'(host_if.busy), 0);
    chk({tag, " loads"}, loads, 1);
    chk({tag, " clrs"}, clrs, 1);
    if (abort_c < 0) begin
      chk({tag, " done count"}, dones, 1);
      chk({tag, " latency"}, done_c, LAT);
      chk({tag, " run cycles"}, runs, WARM_C + LEN);
    end else begin
      chk({tag, " no done"}, dones, 0);
      chk({tag, " run cycles"}, runs, abort_c - 2);
      chk({tag, " result held"}, 32'(host_if.result), last_exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    last_exp      = 0;
    rst_n         = 1'b0;
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    host_if.seed  = '0;
    sc_bit        = 1'b0;

    repeat (2) @(posedge clk);
    #3;
    chk("rst busy",   32'(host_if.busy), 0);
    chk("rst done",   32'(host_if.done), 0);
    chk("rst result", 32'(host_if.result), 0);
    chk("rst load",   32'(sc_load), 0);
    chk("rst seed",   32'(sc_seed), 0);
    chk("rst clr",    32'(sc_clr), 0);
    chk("rst run",    32'(sc_run), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_eval("ones",   8'hA5, 1, 1'b0, -1);
    run_eval("zeros",  8'h3C, 0, 1'b0, -1);
    run_eval("toggle", 8'h77, 2, 1'b0, -1);
    run_eval("seed0",  8'h00, 2, 1'b0, -1);
    run_eval("hold",   8'h12, 2, 1'b1, -1);
    run_eval("abort",  8'h34, 1, 1'b0, RUN_FIRST + 99);

    // Reset in the middle of RUN.
    @(posedge clk); #1;
    host_if.start = 1'b1;
    host_if.seed  = 8'h5A;
    sc_bit        = 1'b1;
    for (int c = 1; c <= RUN_FIRST + 10; c++) begin
      @(posedge clk); #1;
      host_if.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy",   32'(host_if.busy), 0);
    chk("midrst run",    32'(sc_run), 0);
    chk("midrst result", 32'(host_if.result), 0);
    chk("midrst done",   32'(host_if.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_eval("after rst", 8'hC3, 1, 1'b0, -1);
    run_eval("warm window", 8'h81, 3, 1'b0, -1);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
